// File: rtl/lzw_pkg.sv
// Shared sizes and types for the LZW decompression datapath.
package lzw_pkg;

  localparam int CODE_WIDTH      = 11;
  localparam int CHAR_WIDTH      = 8;
  localparam int DICT_DEPTH      = 2 ** CODE_WIDTH;
  localparam int FIRST_FREE_CODE = 2 ** CHAR_WIDTH;
  // Longest decodable string: one suffix per stored entry plus the root char.
  localparam int STACK_DEPTH     = DICT_DEPTH - FIRST_FREE_CODE + 1;
  // next_code must be able to hold DICT_DEPTH itself, hence one extra bit.
  localparam int NEXT_WIDTH      = CODE_WIDTH + 1;
  localparam int SP_WIDTH        = $clog2(STACK_DEPTH + 1);

  typedef logic [CODE_WIDTH-1:0] code_t;
  typedef logic [CHAR_WIDTH-1:0] char_t;
  typedef logic [NEXT_WIDTH-1:0] next_code_t;
  typedef logic [SP_WIDTH-1:0]   sp_t;

  // One dictionary entry: string(code) = string(prefix) followed by suffix.
  typedef struct packed {
    code_t prefix;
    char_t suffix;
  } dict_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    UPDATE,
    EMIT
  } state_t;

  // Codes below FIRST_FREE_CODE are implicit single-char strings.
  function automatic logic is_literal(input code_t code);
    return (code[CODE_WIDTH-1:CHAR_WIDTH] == '0);
  endfunction

endpackage

// File: rtl/lzw_dict_ram.sv
// LZW dictionary storage: one write port, one read port with a registered
// output (one-cycle latency). Contents are not reset; the decoder only reads
// entries below its next_code, which are always freshly written.
module lzw_dict_ram
  import lzw_pkg::*;
(
  input  logic        clk,
  input  logic        wr_en,
  input  code_t       wr_addr,
  input  dict_entry_t wr_data,
  input  code_t       rd_addr,
  output dict_entry_t rd_data
);

  dict_entry_t mem [DICT_DEPTH];
  dict_entry_t rd_data_reg;

  // Write port: commit a new entry when requested.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: the entry for rd_addr is available on rd_data the next cycle.
  always_ff @(posedge clk) begin
    rd_data_reg <= mem[rd_addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/lzw_decoder.sv
// LZW decoder: takes one code per handshake and emits its decoded string one
// char per handshake. Rebuilds the encoder's dictionary on the fly, including
// the KwKwK case where a code refers to the entry being created.
module lzw_decoder
  import lzw_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  code_valid,
  input  logic [CODE_WIDTH-1:0] code_in,
  output logic                  code_ready,
  output logic                  char_valid,
  output logic [CHAR_WIDTH-1:0] char_out,
  input  logic                  char_ready,
  output logic                  dict_full,
  output logic                  err
);

  // Control and history registers
  state_t     state_reg;
  logic       code_ready_reg;
  logic       char_valid_reg;
  char_t      char_out_reg;
  logic       dict_full_reg;
  logic       err_reg;
  logic       first_code_reg;
  logic       kwk_reg;
  code_t      prev_reg;
  char_t      prev_fc_reg;
  code_t      cur_code_reg;
  char_t      root_reg;
  next_code_t next_code_reg;

  // LIFO holding the string suffixes gathered during the walk
  char_t      stack_mem [STACK_DEPTH];
  sp_t        sp_reg;
  sp_t        top_idx;
  char_t      stack_top;

  // Combinational helpers
  next_code_t  code_ext;
  logic        accept;
  logic        code_is_lit;
  logic        code_is_kwk;
  logic        code_bad;
  logic        pop;
  logic        full_after_inc;
  dict_entry_t rd_data;
  dict_entry_t walk_entry;
  logic        walk_done;
  code_t       rd_addr;
  logic        push_en;
  logic        lit_write;
  logic        upd_write;
  logic        wr_en;
  code_t       wr_addr;
  dict_entry_t wr_data;

  assign code_ext    = {1'b0, code_in};
  assign accept      = code_valid && code_ready_reg;
  assign code_is_lit = is_literal(code_in);
  assign code_is_kwk = !first_code_reg && (code_ext == next_code_reg);
  // The very first code has no predecessor, so only a literal can be decoded.
  assign code_bad    = first_code_reg ? !code_is_lit : (code_ext > next_code_reg);
  assign pop         = char_valid_reg && char_ready;
  // True when the pending increment is the one that fills the dictionary.
  assign full_after_inc = (next_code_reg == next_code_t'(DICT_DEPTH - 1));

  // The first walk step of a KwKwK code uses the entry about to be created,
  // {prev, fc(prev)}, which is not in the RAM yet; later steps use the RAM.
  always_comb begin
    walk_entry = rd_data;
    if (kwk_reg) begin
      walk_entry.prefix = prev_reg;
      walk_entry.suffix = prev_fc_reg;
    end
  end

  assign walk_done = is_literal(walk_entry.prefix);
  // In IDLE the incoming code is looked up so its entry is ready in WALK.
  assign rd_addr   = (state_reg == WALK) ? walk_entry.prefix : code_in;
  assign push_en   = (state_reg == WALK);

  // Literal codes update the dictionary directly at accept; strings do it in UPDATE.
  assign lit_write = (state_reg == IDLE) && accept && !code_bad && !first_code_reg &&
                     code_is_lit && !dict_full_reg;
  assign upd_write = (state_reg == UPDATE) && !dict_full_reg;
  // An edge that lands while reset is held must not commit an entry.
  assign wr_en     = rst && (lit_write || upd_write);
  assign wr_addr   = next_code_reg[CODE_WIDTH-1:0];

  // New entry is {prev, first char of the current string}.
  always_comb begin
    wr_data.prefix = prev_reg;
    wr_data.suffix = (state_reg == UPDATE) ? root_reg : code_in[CHAR_WIDTH-1:0];
  end

  assign top_idx   = (sp_reg == '0) ? '0 : sp_reg - 1'b1;
  assign stack_top = stack_mem[top_idx];

  lzw_dict_ram u_dict_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // LIFO storage: one suffix pushed per walk step.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[sp_reg] <= walk_entry.suffix;
    end
  end

  // Decoder FSM with registered handshake outputs and dictionary bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      code_ready_reg <= 1'b1;
      char_valid_reg <= 1'b0;
      char_out_reg   <= '0;
      dict_full_reg  <= 1'b0;
      err_reg        <= 1'b0;
      first_code_reg <= 1'b1;
      kwk_reg        <= 1'b0;
      prev_reg       <= '0;
      prev_fc_reg    <= '0;
      cur_code_reg   <= '0;
      root_reg       <= '0;
      next_code_reg  <= next_code_t'(FIRST_FREE_CODE);
      sp_reg         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            cur_code_reg <= code_in;
            if (code_bad) begin
              // Undecodable code: flag it, drop it, keep prev and next_code.
              err_reg <= 1'b1;
            end else if (code_is_lit) begin
              first_code_reg <= 1'b0;
              prev_reg       <= code_in;
              prev_fc_reg    <= code_in[CHAR_WIDTH-1:0];
              char_out_reg   <= code_in[CHAR_WIDTH-1:0];
              char_valid_reg <= 1'b1;
              code_ready_reg <= 1'b0;
              state_reg      <= EMIT;
              if (!first_code_reg && !dict_full_reg) begin
                next_code_reg <= next_code_reg + 1'b1;
                dict_full_reg <= full_after_inc;
              end
            end else begin
              kwk_reg        <= code_is_kwk;
              code_ready_reg <= 1'b0;
              state_reg      <= WALK;
            end
          end
        end

        WALK: begin
          kwk_reg <= 1'b0;
          sp_reg  <= sp_reg + 1'b1;
          // A literal prefix is the root of the string, i.e. its first char.
          if (walk_done) begin
            root_reg  <= walk_entry.prefix[CHAR_WIDTH-1:0];
            state_reg <= UPDATE;
          end
        end

        UPDATE: begin
          if (!dict_full_reg) begin
            next_code_reg <= next_code_reg + 1'b1;
            dict_full_reg <= full_after_inc;
          end
          prev_reg       <= cur_code_reg;
          prev_fc_reg    <= root_reg;
          // The root is emitted straight away; the stack holds the rest.
          char_out_reg   <= root_reg;
          char_valid_reg <= 1'b1;
          state_reg      <= EMIT;
        end

        EMIT: begin
          if (pop) begin
            if (sp_reg == '0) begin
              char_valid_reg <= 1'b0;
              code_ready_reg <= 1'b1;
              state_reg      <= IDLE;
            end else begin
              char_out_reg <= stack_top;
              sp_reg       <= sp_reg - 1'b1;
            end
          end
        end

        default: begin
          state_reg      <= IDLE;
          code_ready_reg <= 1'b1;
          char_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign code_ready = code_ready_reg;
  assign char_valid = char_valid_reg;
  assign char_out   = char_out_reg;
  assign dict_full  = dict_full_reg;
  assign err        = err_reg;

endmodule
